fpu_add_normalise: RTL and testbench



---
 rtl/fpu_add_normalise.sv | 197 +++++++++++++++++++
 tb/tb_fpu_add_normalise.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_add_normalise.sv
`timescale 1ns/1ps
// Post-add normalise / round-to-nearest-even / pack stage of the binary32 adder.
// Define FPU_NORM_DENORM_EN for gradual underflow; otherwise sub-minimum results flush to signed zero.
module fpu_add_normalise (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [27:0] sum_in,
    input  logic [9:0]  z_e_in,
    input  logic        z_s_in,
    output logic [31:0] z_out,
    output logic        out_valid,
    input  logic        out_ready
);

    // state  | meaning
    // IDLE   | waiting for an operand, in_ready high
    // ALIGN  | split captured sum into z_m/g/r/s
    // NORM_L | left shift until hidden bit set or exponent at minimum
    // NORM_R | right shift up to the minimum exponent (gradual underflow build)
    // ROUND  | round to nearest even
    // PACK   | assemble the binary32 word
    // DONE   | result presented until out_ready
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ALIGN  = 3'd1,
        NORM_L = 3'd2,
`ifdef FPU_NORM_DENORM_EN
        NORM_R = 3'd3,
`endif
        ROUND  = 3'd4,
        PACK   = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam logic signed [9:0] E_MIN = -10'sd126;
    localparam logic signed [9:0] E_MAX = 10'sd127;

    state_t             state_q, state_d;
    logic [27:0]        sum_q;
    logic signed [9:0]  z_e;
    logic               z_s;
    logic [23:0]        z_m;
    logic               g, r, s;
    logic               shift_l;
    logic [7:0]         exp_field;
    logic [31:0]        pack_w;
`ifndef FPU_NORM_DENORM_EN
    logic               norm_done;
    logic               flush;
`else
    logic               shift_r;
    assign shift_r = (z_e < E_MIN);
`endif

    assign shift_l   = !z_m[23] && (z_e > E_MIN);
    assign exp_field = z_e[7:0] + 8'd127;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ALIGN;
            end
            // a zero sum bypasses normalise/round; PACK then emits +0
            ALIGN:  state_d = (sum_q == 28'd0) ? PACK : NORM_L;
            NORM_L: begin
`ifdef FPU_NORM_DENORM_EN
                if (!shift_l) state_d = NORM_R;
`else
                if (!shift_l && norm_done) state_d = ROUND;
`endif
            end
`ifdef FPU_NORM_DENORM_EN
            NORM_R: if (!shift_r) state_d = ROUND;
`endif
            ROUND:  state_d = PACK;
            PACK:   state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pack_w = {z_s, exp_field, z_m[22:0]};
        if (z_e > E_MAX)
            pack_w = {z_s, 8'hFF, 23'h0};
        else if (z_e == E_MIN && !z_m[23])
            pack_w = {z_s, 8'h00, z_m[22:0]};
`ifndef FPU_NORM_DENORM_EN
        if (flush) pack_w = {z_s, 31'h0};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            z_e       <= '0;
            z_s       <= 1'b0;
            z_m       <= '0;
            g         <= 1'b0;
            r         <= 1'b0;
            s         <= 1'b0;
            z_out     <= '0;
`ifndef FPU_NORM_DENORM_EN
            norm_done <= 1'b0;
            flush     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sum_q <= sum_in;
                        z_e   <= z_e_in;
                        z_s   <= z_s_in;
                    end
                end
                ALIGN: begin
`ifndef FPU_NORM_DENORM_EN
                    norm_done <= 1'b0;
                    flush     <= 1'b0;
`endif
                    if (sum_q == 28'd0) begin
                        z_m <= '0;
                        g   <= 1'b0;
                        r   <= 1'b0;
                        s   <= 1'b0;
                        z_s <= 1'b0;
                        z_e <= E_MIN;
                    end else if (sum_q[27]) begin
                        z_m <= sum_q[27:4];
                        g   <= sum_q[3];
                        r   <= sum_q[2];
                        s   <= sum_q[1] | sum_q[0];
                        z_e <= z_e + 10'sd1;
                    end else begin
                        z_m <= sum_q[26:3];
                        g   <= sum_q[2];
                        r   <= sum_q[1];
                        s   <= sum_q[0];
                    end
                end
                NORM_L: begin
                    if (shift_l) begin
                        z_m <= {z_m[22:0], g};
                        g   <= r;
                        r   <= 1'b0;
                        z_e <= z_e - 10'sd1;
                    end
`ifndef FPU_NORM_DENORM_EN
                    else begin
                        // extra settle cycle keeps latency equal to the gradual-underflow build
                        norm_done <= 1'b1;
                        flush     <= (z_e < E_MIN) || !z_m[23];
                    end
`endif
                end
`ifdef FPU_NORM_DENORM_EN
                NORM_R: begin
                    if (shift_r) begin
                        z_m <= {1'b0, z_m[23:1]};
                        g   <= z_m[0];
                        r   <= g;
                        s   <= s | r;
                        z_e <= z_e + 10'sd1;
                    end
                end
`endif
                ROUND: begin
                    if (g && (r || s || z_m[0])) begin
                        if (&z_m) begin
                            z_m <= 24'h800000;
                            z_e <= z_e + 10'sd1;
                        end else begin
                            z_m <= z_m + 24'd1;
                        end
                    end
                end
                PACK:    z_out <= pack_w;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_add_normalise.sv
`timescale 1ns/1ps
// Self-checking bench for fpu_add_normalise: arithmetic reference model plus per-cycle output compare.
module tb_fpu_add_normalise;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [27:0] sum_in = '0;
    logic [9:0]  z_e_in = '0;
    logic        z_s_in = 1'b0;
    logic [31:0] z_out;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [31:0] pend_z = '0;
    int          pend_lat = 0;
    logic [31:0] cur_z = '0;
    int          cur_lat = 0;
    int          cnt = 0;
    bit          busy = 1'b0;

    always #5 clk = ~clk;

    fpu_add_normalise dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .z_e_in    (z_e_in),
        .z_s_in    (z_s_in),
        .z_out     (z_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic checki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    // Value = A * 2^(e-25) with A a 26-bit integer {24 mantissa bits, guard, round} and a separate sticky.
    function automatic void model(input logic [27:0] sum, input logic [9:0] ze, input logic zs,
                                  output logic [31:0] z, output int lat);
        int e, p, l, r, lmax;
        longint unsigned a, m;
        bit st, flush;
        logic [7:0] ef;
        e = int'($signed(ze));
        flush = 1'b0;
        r = 0;
        if (sum == 28'd0) begin
            z = 32'h0;
            lat = 2;
            return;
        end
        if (sum[27]) begin
            a = longint'(sum[27:2]);
            st = |sum[1:0];
            e = e + 1;
        end else begin
            a = longint'(sum[26:1]);
            st = sum[0];
        end
        p = -1;
        for (int i = 0; i < 26; i++) if (a[i]) p = i;
        lmax = (e > -126) ? e + 126 : 0;
        l = (p < 0 || 25 - p > lmax) ? lmax : 25 - p;
        a = a << l;
        e = e - l;
`ifdef FPU_NORM_DENORM_EN
        if (e < -126) begin
            r = -126 - e;
            st = st | ((a & ((64'd1 << r) - 64'd1)) != 64'd0);
            a = a >> r;
            e = e + r;
        end
`else
        flush = (e < -126) || (e == -126 && !a[25]);
`endif
        m = a >> 2;
        if (a[1] && (a[0] || st || m[0])) m = m + 64'd1;
        if (m == (64'd1 << 24)) begin
            m = 64'd1 << 23;
            e = e + 1;
        end
        ef = 8'(e + 127);
        if (flush)                    z = {zs, 31'd0};
        else if (e > 127)             z = {zs, 8'hFF, 23'd0};
        else if (e == -126 && !m[23]) z = {zs, 8'h00, m[22:0]};
        else                          z = {zs, ef, m[22:0]};
        lat = 5 + l + r;
    endfunction

    // Transaction bookkeeping: accept and handshake seen on the clock edge itself.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                busy = 1'b0;
            end else if (busy) begin
                if (out_valid && out_ready) busy = 1'b0;
                else cnt++;
            end else if (in_valid && in_ready) begin
                busy = 1'b1;
                cnt = 0;
                cur_z = pend_z;
                cur_lat = pend_lat;
            end
        end
    end

    // Per-cycle compare against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check32("rst_out_valid", {31'd0, out_valid}, 32'd0);
                check32("rst_in_ready", {31'd0, in_ready}, 32'd1);
                check32("rst_z_out", z_out, 32'd0);
            end else begin
                check32("in_ready", {31'd0, in_ready}, {31'd0, !busy});
                if (busy) begin
                    check32("out_valid", {31'd0, out_valid}, {31'd0, cnt >= cur_lat});
                    if (out_valid) check32("z_out", z_out, cur_z);
                end else begin
                    check32("out_valid_idle", {31'd0, out_valid}, 32'd0);
                end
            end
        end
    end

    task automatic issue(input logic [27:0] s, input logic [9:0] e, input logic sg);
        logic [31:0] mz;
        int ml, n;
        model(s, e, sg, mz, ml);
        pend_z = mz;
        pend_lat = ml;
        @(negedge clk);
        sum_in = s;
        z_e_in = e;
        z_s_in = sg;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check32("accept_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run(input string nm, input logic [27:0] s, input logic [9:0] e, input logic sg,
                       input bit pin, input logic [31:0] pz, input int pl, input int hold);
        logic [31:0] mz;
        int ml, n;
        if (pin) begin
            model(s, e, sg, mz, ml);
            check32({nm, "_model_z"}, mz, pz);
            checki({nm, "_model_lat"}, ml, pl);
        end
        out_ready = (hold == 0);
        issue(s, e, sg);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check32({nm, "_done_timeout"}, {31'd0, out_valid}, 32'd1);
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        run("one_plus_one", 28'h8000000, 10'd0, 1'b0, 1'b1, 32'h40000000, 5, 0);
        run("one_minus_half", 28'h2000000, 10'd0, 1'b0, 1'b1, 32'h3F000000, 6, 0);
        run("tie_even", 28'h4000004, 10'd0, 1'b0, 1'b1, 32'h3F800000, 5, 0);
        run("tie_odd", 28'h400000C, 10'd0, 1'b0, 1'b1, 32'h3F800002, 5, 0);
        run("mant_carry", 28'h7FFFFFC, 10'd0, 1'b0, 1'b1, 32'h40000000, 5, 0);
        run("overflow", 28'h8000000, 10'd127, 1'b0, 1'b1, 32'h7F800000, 5, 0);
        run("zero", 28'h0000000, 10'd5, 1'b1, 1'b1, 32'h00000000, 2, 0);
        run("carry_sticky", 28'h8000009, 10'd0, 1'b0, 1'b1, 32'h40000001, 5, 0);
        run("max_normal", 28'h4000000, 10'd127, 1'b0, 1'b1, 32'h7F000000, 5, 0);
        run("negative", 28'h6000000, 10'd3, 1'b1, 1'b1, 32'hC1400000, 5, 0);
        run("low_normal", 28'h0400000, 10'h388, 1'b0, 1'b1, 32'h01800000, 9, 0);
`ifdef FPU_NORM_DENORM_EN
        run("underflow", 28'h4000000, 10'h380, 1'b0, 1'b1, 32'h00200000, 7, 0);
        run("deep_underflow", 28'h7FFFFFF, 10'h36A, 1'b0, 1'b1, 32'h00000001, 29, 0);
`else
        run("underflow", 28'h4000000, 10'h380, 1'b0, 1'b1, 32'h00000000, 5, 0);
        run("deep_underflow", 28'h7FFFFFF, 10'h36A, 1'b0, 1'b1, 32'h00000000, 5, 0);
`endif
        run("subnorm_stop", 28'h0400000, 10'h384, 1'b1, 1'b0, 32'h0, 0, 0);
        run("hold_out", 28'h400000C, 10'd2, 1'b1, 1'b1, 32'hC080_0002, 5, 10);
        run("long_left", 28'h0000010, 10'd0, 1'b0, 1'b1, 32'h34800000, 27, 3);

        // abort a long left-normalisation with reset, then confirm recovery
        issue(28'h0000010, 10'd0, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check32("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check32("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run("after_reset", 28'h2000000, 10'd0, 1'b0, 1'b1, 32'h3F000000, 6, 0);
        run("after_reset2", 28'h8000000, 10'd0, 1'b1, 1'b1, 32'hC0000000, 5, 2);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
